cpu_control: RTL
================

// Module: cpu_control
// PURPOSE
//  Multicycle sequencer for the CPU datapath. Steps each instruction through FETCH, DECODE,
//  EXECUTE, MEMORY and WRITEBACK, generating the enables for the memory interface, instruction
//  register, decode stage, ALU, register file and PC. Handshakes with memory via mem_ready,
//  traps unsupported opcodes and counts retired instructions.
// PARAMETERS
//  COUNT_WIDTH  32  width of the instret retired-instruction counter
// PORTS
//  clock                input   1  rising-edge clock
//  reset                input   1  synchronous, active-low
//  opcode               input   7  opcode from decode, valid during DECODE cycle
//  func3                input   3  func3 from decode, valid during DECODE cycle
//  mem_ready            input   1  memory completed current read/write this cycle
//  branch_taken         input   1  ALU branch compare result, valid in EXECUTE
//  mem_read             output  1  memory read request (fetch or load)
//  mem_write            output  1  memory write request (store)
//  mem_is_fetch         output  1  1 = address from PC, 0 = address from ALU
//  ir_write             output  1  latch instruction word (one-cycle pulse)
//  decode_enable        output  1  decode stage clock enable
//  alu_enable           output  1  ALU operand/result register enable
//  reg_write            output  1  register file write enable
//  wb_select            output  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate
//  pc_write             output  1  PC update enable
//  pc_source            output  2  00 PC+4, 01 PC+imm (branch/JAL), 10 rs1+imm (JALR)
//  illegal_instruction  output  1  held high while in ILLEGAL
//  state                output  3  current state code (debug)
//  instret              output  COUNT_WIDTH  retired-instruction count
// BEHAVIOUR
//  - State codes: FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 ILLEGAL=5; 6,7 -> FETCH.
//  - reset low at a rising edge: state<=FETCH, instret<=0, latched opcode/func3<=0. While
//    reset is low all control outputs are forced 0 combinationally (state still reports 0).
//  - Outputs are combinational from state, latched opcode/func3, mem_ready and branch_taken.
//  - FETCH: mem_read=1, mem_is_fetch=1; stay until mem_ready=1; that cycle ir_write=1 -> DECODE.
//  - DECODE: decode_enable=1; opcode/func3 latched at end of cycle; legality checked ->
//    EXECUTE if legal, else ILLEGAL.
//  - Legal: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (func3=000),
//    BRANCH 1100011 (func3 not 010/011), LOAD 0000011 (func3 000,001,010,100,101),
//    STORE 0100011 (func3 000-010), OP-IMM 0010011, OP 0110011. All others illegal.
//  - EXECUTE: alu_enable=1. LOAD/STORE -> MEMORY. BRANCH: pc_write=1,
//    pc_source=branch_taken?01:00, retire, -> FETCH. All others -> WRITEBACK.
//  - MEMORY: mem_is_fetch=0; LOAD mem_read=1, STORE mem_write=1, held until mem_ready=1.
//    On mem_ready: LOAD -> WRITEBACK; STORE pc_write=1, pc_source=00, retire, -> FETCH.
//  - WRITEBACK: reg_write=1, pc_write=1, retire, -> FETCH. wb_select: LUI 11, JAL/JALR 10,
//    LOAD 01, else 00. pc_source: JAL 01, JALR 10, else 00.
//  - ILLEGAL: illegal_instruction=1, no other control asserted, no retire; exit only by reset.
//  - Retire: instret+1 at the edge ending the retiring cycle; wraps all-ones -> 0.
//  - Latency with mem_ready always 1: branch 3, OP/OP-IMM/LUI/AUIPC/JAL/JALR/store 4, load 5.
//  - Each mem_ready-low cycle extends FETCH or MEMORY by one cycle; mem_ready is ignored in
//    all other states.
//  - Reset mid-transaction abandons it: mem_read/mem_write drop in the same cycle; no retire.
// TESTING
//  1. reset low 3 cycles, mem_ready=1 -> all outputs 0, state=0, instret=0; release ->
//     mem_read=1, mem_is_fetch=1 next cycle.
//  2. ADDI (0010011), mem_ready=1 -> states 0,1,2,4,0; in WRITEBACK reg_write=1, wb_select=00,
//     pc_write=1, pc_source=00; instret=1.
//  3. LW (0000011/010), fetch mem_ready late by 3 cycles, data late by 2 -> FETCH 4 cycles,
//     MEMORY 3 cycles (mem_read=1, mem_is_fetch=0), wb_select=01; 10 cycles total, instret+1.
//  4. BEQ with branch_taken=1 -> EXECUTE pc_write=1, pc_source=01, reg_write=0, -> FETCH;
//     repeat with branch_taken=0 -> pc_source=00; instret +1 each.
//  5. JALR with func3=001 -> ILLEGAL, illegal_instruction=1 for 20 cycles, pc_write=0,
//     instret unchanged; reset clears it.
//  6. SW with mem_ready=0 in MEMORY, reset low mid-MEMORY -> mem_write=0 that cycle,
//     state=FETCH next edge, instret=0.

Source files
------------

// File: rtl/cpu_control.sv
// cpu_control: multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the CPU datapath.
// Generates memory, IR, decode, ALU, register-file and PC enables; traps illegal opcodes; counts retires.
module cpu_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [6:0]             opcode,
    input  logic [2:0]             func3,
    input  logic                   mem_ready,
    input  logic                   branch_taken,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem_is_fetch,
    output logic                   ir_write,
    output logic                   decode_enable,
    output logic                   alu_enable,
    output logic                   reg_write,
    output logic [1:0]             wb_select,
    output logic                   pc_write,
    output logic [1:0]             pc_source,
    output logic                   illegal_instruction,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] instret
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_ILLEGAL   = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [2:0]             state_q;
    logic [2:0]             state_d;
    logic [6:0]             op_q;
    logic [COUNT_WIDTH-1:0] instret_q;
    logic                   retire;

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_OP: is_legal = 1'b1;
            OP_JALR:   is_legal = (f3 == 3'b000);
            OP_BRANCH: is_legal = (f3 != 3'b010) && (f3 != 3'b011);
            OP_LOAD:   is_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                                  (f3 == 3'b100) || (f3 == 3'b101);
            OP_STORE:  is_legal = (f3 <= 3'b010);
            default:   is_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Only the opcode is kept past DECODE; func3 matters solely for the legality check there.
    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q      <= 7'd0;
            instret_q <= '0;
        end else begin
            if (state_q == S_DECODE) op_q <= opcode;
            if (retire) instret_q <= instret_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = is_legal(opcode, func3) ? S_EXECUTE : S_ILLEGAL;
            S_EXECUTE: begin
                if (op_q == OP_LOAD || op_q == OP_STORE) state_d = S_MEMORY;
                else if (op_q == OP_BRANCH)              state_d = S_FETCH;
                else                                     state_d = S_WRITEBACK;
            end
            S_MEMORY:    if (mem_ready) state_d = (op_q == OP_LOAD) ? S_WRITEBACK : S_FETCH;
            S_WRITEBACK: state_d = S_FETCH;
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_FETCH;
        endcase
    end

    // Memory handshake: mem_read/mem_write stay asserted every cycle of FETCH/MEMORY until the
    // cycle in which mem_ready is high; that cycle completes the transfer and the FSM advances.
    always_comb begin
        mem_read            = 1'b0;
        mem_write           = 1'b0;
        mem_is_fetch        = 1'b0;
        ir_write            = 1'b0;
        decode_enable       = 1'b0;
        alu_enable          = 1'b0;
        reg_write           = 1'b0;
        wb_select           = 2'b00;
        pc_write            = 1'b0;
        pc_source           = 2'b00;
        illegal_instruction = 1'b0;
        retire              = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read     = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_write     = mem_ready;
                end
                S_DECODE:  decode_enable = 1'b1;
                S_EXECUTE: begin
                    alu_enable = 1'b1;
                    if (op_q == OP_BRANCH) begin
                        pc_write  = 1'b1;
                        pc_source = branch_taken ? 2'b01 : 2'b00;
                        retire    = 1'b1;
                    end
                end
                S_MEMORY: begin
                    mem_read  = (op_q == OP_LOAD);
                    mem_write = (op_q == OP_STORE);
                    if (op_q == OP_STORE && mem_ready) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    case (op_q)
                        OP_LUI:           wb_select = 2'b11;
                        OP_JAL, OP_JALR:  wb_select = 2'b10;
                        OP_LOAD:          wb_select = 2'b01;
                        default:          wb_select = 2'b00;
                    endcase
                    if (op_q == OP_JAL)       pc_source = 2'b01;
                    else if (op_q == OP_JALR) pc_source = 2'b10;
                end
                S_ILLEGAL: illegal_instruction = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = reset ? state_q : S_FETCH;
    assign instret = instret_q;

endmodule
